// File: rtl/serial_rx_box_if.sv
// Strobe/ack byte port of serial_rx_box together with its framing-error and overflow pulses.
interface serial_rx_box_if;
  logic       O_STB;
  logic [7:0] O_DATA;
  logic       O_ACK;
  logic       O_FERR;
  logic       O_OVF;

  modport master (output O_STB, output O_DATA, input O_ACK, output O_FERR, output O_OVF);
  modport slave  (input O_STB, input O_DATA, output O_ACK, input O_FERR, input O_OVF);
endinterface

// File: rtl/serial_rx_box.sv
// serial_rx_box: 8N1 UART receiver, 8 ticks per bit, FIFO presented on a strobe/ack port.
// Build option SERIAL_RX_MAJORITY_EN: each bit decided by a 2-of-3 vote over ticks 3..5.
module serial_rx_box #(
  parameter int FIFO_DEPTH = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            I_RxD,
  input  logic [15:0]     CFG_CLK_DIV,
  serial_rx_box_if.master bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic        r_sync1, r_sync2, r_rxs_d;
  logic [1:0]  r_warm;
  state_t      r_state;
  logic [15:0] r_div, r_sc_cntl;
  logic [2:0]  r_sc_cnth, r_bitn;
  logic [7:0]  r_sh, r_push_data;
  logic        r_push, r_ferr;
  logic        w_rxs, w_fall, w_tick, w_bit_end, w_samp_pt, w_samp;
  logic [15:0] w_div;

  assign w_rxs     = r_sync2;
  assign w_fall    = r_rxs_d & ~r_sync2;
  assign w_div     = (CFG_CLK_DIV == 16'd0) ? 16'd1 : CFG_CLK_DIV;
  assign w_tick    = (r_sc_cntl == r_div);
  assign w_bit_end = w_tick && (r_sc_cnth == 3'd7);

  // The edge register is held low for two clocks after reset so a line already low never counts as a start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b0;
      r_warm  <= 2'd0;
    end else begin
      r_sync1 <= I_RxD;
      r_sync2 <= r_sync1;
      if (r_warm != 2'd2) begin
        r_warm  <= r_warm + 2'd1;
        r_rxs_d <= 1'b0;
      end else begin
        r_rxs_d <= r_sync2;
      end
    end
  end

`ifdef SERIAL_RX_MAJORITY_EN
  logic [1:0] r_maj;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign w_samp_pt = w_tick && (r_sc_cnth == 3'd4);
  assign w_samp    = maj3(r_maj[1], r_maj[0], w_rxs);

  // Ticks 3 and 4 are captured here; tick 5 is taken live at the decision point.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_maj <= 2'b11;
    end else if (w_tick && ((r_sc_cnth == 3'd2) || (r_sc_cnth == 3'd3))) begin
      r_maj <= {r_maj[0], w_rxs};
    end
  end
`else
  assign w_samp_pt = w_tick && (r_sc_cnth == 3'd3);
  assign w_samp    = w_rxs;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_div       <= 16'd1;
      r_sc_cntl   <= 16'd1;
      r_sc_cnth   <= 3'd0;
      r_bitn      <= 3'd0;
      r_sh        <= 8'h00;
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
      r_ferr      <= 1'b0;
    end else begin
      r_push <= 1'b0;
      r_ferr <= 1'b0;
      if (w_tick) begin
        r_sc_cntl <= 16'd1;
        r_sc_cnth <= r_sc_cnth + 3'd1;
      end else begin
        r_sc_cntl <= r_sc_cntl + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          r_div     <= w_div;
          r_sc_cntl <= 16'd1;
          r_sc_cnth <= 3'd0;
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (w_samp_pt && w_samp) begin
            r_state <= S_IDLE;
          end else if (w_bit_end) begin
            r_state <= S_DATA;
            r_bitn  <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_samp_pt) r_sh <= {w_samp, r_sh[7:1]};
          if (w_bit_end) begin
            r_bitn <= r_bitn + 3'd1;
            if (r_bitn == 3'd7) r_state <= S_STOP;
          end
        end
        // Leaving at mid-stop-bit gives half a bit of slack for baud drift.
        S_STOP: begin
          if (w_samp_pt) begin
            if (w_samp) begin
              r_push      <= 1'b1;
              r_push_data <= r_sh;
              r_state     <= S_IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (w_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd, r_wr, w_rd_nx;
  logic [AW:0]   r_cnt, w_cnt_nx;
  logic [7:0]    r_data, w_head_nx;
  logic          r_stb, r_ovf, w_pop, w_full, w_wr_en, w_ovf;

  assign w_pop   = r_stb & bus.O_ACK;
  assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_wr_en = r_push & (~w_full | w_pop);
  assign w_ovf   = r_push & w_full & ~w_pop;
  assign w_rd_nx = w_pop ? (r_rd + AW'(1)) : r_rd;

  always_comb begin
    w_cnt_nx = r_cnt;
    if (w_wr_en && !w_pop) begin
      w_cnt_nx = r_cnt + (AW+1)'(1);
    end else if (!w_wr_en && w_pop) begin
      w_cnt_nx = r_cnt - (AW+1)'(1);
    end else begin
      w_cnt_nx = r_cnt;
    end
  end

  // A byte written into the slot that becomes the head this cycle bypasses the array.
  always_comb begin
    w_head_nx = r_data;
    if (w_cnt_nx == (AW+1)'(0)) begin
      w_head_nx = r_data;
    end else if (w_wr_en && (w_rd_nx == r_wr)) begin
      w_head_nx = r_push_data;
    end else begin
      w_head_nx = r_mem[w_rd_nx];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr] <= r_push_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd   <= {AW{1'b0}};
      r_wr   <= {AW{1'b0}};
      r_cnt  <= {(AW+1){1'b0}};
      r_stb  <= 1'b0;
      r_data <= 8'h00;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + AW'(1);
      r_rd   <= w_rd_nx;
      r_cnt  <= w_cnt_nx;
      r_stb  <= (w_cnt_nx != (AW+1)'(0));
      r_data <= w_head_nx;
      r_ovf  <= w_ovf;
    end
  end

  assign bus.O_STB  = r_stb;
  assign bus.O_DATA = r_data;
  assign bus.O_FERR = r_ferr;
  assign bus.O_OVF  = r_ovf;
endmodule

// File: tb/tb_serial_rx_box.sv
// Self-checking bench for serial_rx_box: frame-level UART driver, FIFO scoreboard, event counters.
module tb_serial_rx_box;
  localparam int DEPTH = 32;
`ifdef SERIAL_RX_MAJORITY_EN
  localparam int DECIDE_TICK = 77;
`else
  localparam int DECIDE_TICK = 76;
`endif

  logic        CLK;
  logic        RST;
  logic        I_RxD;
  logic [15:0] CFG_CLK_DIV;

  serial_rx_box_if bus ();

  serial_rx_box #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .I_RxD(I_RxD), .CFG_CLK_DIV(CFG_CLK_DIV), .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0, ovf_cnt = 0, stb_cycles = 0;
  int exp_ferr = 0, exp_ovf = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < rx_log.size()) return {24'd0, rx_log[i]};
    return 32'hDEAD;
  endfunction

  // FIFO model: a good byte is kept unless the FIFO is full with no pop planned at its write.
  task automatic model_push(input logic [7:0] b, input bit pop_planned);
    if (exp_q.size() >= DEPTH && !pop_planned) exp_ovf++;
    else exp_q.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bitclk, input bit stop_ok,
                            input bit pop_planned = 1'b0);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    if (stop_ok) model_push(b, pop_planned);
    else exp_ferr++;
    for (int i = 0; i < 10; i++) begin
      I_RxD = fr[i];
      repeat (bitclk) @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string tag);
    bus.O_ACK = 1'b1;
    wait_clk(DEPTH + 8);
    bus.O_ACK = 1'b0;
    wait_clk(1);
    check({tag, "_empty"}, bus.O_STB, 32'd0);
  endtask

  task automatic loopback(input int txdiv, input logic [15:0] rxcfg, input int n, input string tag);
    int base, f0;
    CFG_CLK_DIV = rxcfg;
    wait_clk(4);
    base = rx_log.size();
    f0 = ferr_cnt;
    for (int i = 0; i < n; i++) send_frame(8'($urandom), 8 * txdiv, 1'b1);
    wait_clk(16 * txdiv + 20);
    check({tag, "_count"}, rx_log.size() - base, n);
    check({tag, "_ferr"}, ferr_cnt - f0, 32'd0);
  endtask

  // Compare process: every cycle with O_STB high, the head must equal the model's oldest byte.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (bus.O_FERR === 1'b1) ferr_cnt++;
      if (bus.O_OVF === 1'b1) ovf_cnt++;
      if (bus.O_STB === 1'b1) begin
        stb_cycles++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL head_spurious: got 0x%02h, required no byte", bus.O_DATA);
        end else begin
          check("head", {24'd0, bus.O_DATA}, {24'd0, exp_q[0]});
          if (bus.O_ACK === 1'b1) begin
            rx_log.push_back(bus.O_DATA);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s0, f0;
    RST = 1'b1;
    I_RxD = 1'b1;
    bus.O_ACK = 1'b0;
    CFG_CLK_DIV = 16'd4;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_stb", bus.O_STB, 32'd0);
    check("rst_data", bus.O_DATA, 32'd0);
    check("rst_ferr", bus.O_FERR, 32'd0);
    check("rst_ovf", bus.O_OVF, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    wait_clk(10);

    // Two back-to-back characters with ack tied high.
    bus.O_ACK = 1'b1;
    base = rx_log.size();
    s0 = stb_cycles;
    send_frame(8'h55, 32, 1'b1);
    send_frame(8'hA3, 32, 1'b1);
    wait_clk(64);
    check("t1_count", rx_log.size() - base, 32'd2);
    check("t1_byte0", log_at(base), 32'h55);
    check("t1_byte1", log_at(base + 1), 32'hA3);
    check("t1_stb_cycles", stb_cycles - s0, 32'd2);
    check("t1_ferr", ferr_cnt, 32'd0);
    check("t1_ovf", ovf_cnt, 32'd0);

    // Short low glitch must be rejected silently.
    base = rx_log.size();
    s0 = stb_cycles;
    I_RxD = 1'b0;
    wait_clk(8);
    I_RxD = 1'b1;
    wait_clk(128);
    check("t2_no_stb", stb_cycles - s0, 32'd0);
    check("t2_ferr", ferr_cnt, 32'd0);
    send_frame(8'h3C, 32, 1'b1);
    wait_clk(64);
    check("t2_byte", log_at(base), 32'h3C);

    // Bad stop bit followed by a held-low line: one error, no byte.
    CFG_CLK_DIV = 16'd2;
    wait_clk(4);
    base = rx_log.size();
    send_frame(8'h81, 16, 1'b0);
    wait_clk(48);
    I_RxD = 1'b1;
    wait_clk(64);
    check("t3_ferr", ferr_cnt, 32'd1);
    check("t3_ferr_model", ferr_cnt, exp_ferr);
    check("t3_no_byte", rx_log.size() - base, 32'd0);
    send_frame(8'h7E, 16, 1'b1);
    wait_clk(40);
    check("t3_byte", log_at(base), 32'h7E);

    // Overflow: 33 bytes with ack low, last is dropped.
    CFG_CLK_DIV = 16'd1;
    bus.O_ACK = 1'b0;
    wait_clk(4);
    base = rx_log.size();
    for (int i = 0; i < 33; i++) send_frame(8'(i), 8, 1'b1);
    wait_clk(20);
    check("t4_ovf", ovf_cnt, 32'd1);
    check("t4_ovf_model", ovf_cnt, exp_ovf);
    drain("t4");
    check("t4_count", rx_log.size() - base, 32'd32);
    for (int i = 0; i < 32; i += 31) check("t4_order", log_at(base + i), 32'(i));

    // Full FIFO with a pop on the same edge as the push: no overflow, new byte lands last.
    base = rx_log.size();
    for (int i = 0; i < 32; i++) send_frame(8'h40 + 8'(i), 8, 1'b1);
    wait_clk(10);
    fork
      send_frame(8'h99, 8, 1'b1, 1'b1);
      begin
        repeat (DECIDE_TICK * 1 + 3) @(posedge CLK);
        #1;
        bus.O_ACK = 1'b1;
        @(posedge CLK);
        #1;
        bus.O_ACK = 1'b0;
      end
    join
    wait_clk(10);
    check("t5_no_ovf", ovf_cnt, 32'd1);
    check("t5_one_popped", rx_log.size() - base, 32'd1);
    drain("t5");
    check("t5_count", rx_log.size() - base, 32'd33);
    check("t5_first", log_at(base), 32'h40);
    check("t5_last", log_at(base + 32), 32'h99);

    // Reset mid-character with bytes buffered and the line left low across release.
    CFG_CLK_DIV = 16'd4;
    wait_clk(4);
    send_frame(8'h11, 32, 1'b1);
    send_frame(8'h22, 32, 1'b1);
    wait_clk(40);
    I_RxD = 1'b0;
    wait_clk(100);
    RST = 1'b1;
    exp_q.delete();
    wait_clk(3);
    check("t6_rst_stb", bus.O_STB, 32'd0);
    RST = 1'b0;
    s0 = stb_cycles;
    f0 = ferr_cnt;
    wait_clk(96);
    I_RxD = 1'b1;
    wait_clk(64);
    check("t6_no_stb", stb_cycles - s0, 32'd0);
    check("t6_no_ferr", ferr_cnt - f0, 32'd0);
    bus.O_ACK = 1'b1;
    base = rx_log.size();
    send_frame(8'hC5, 32, 1'b1);
    wait_clk(64);
    check("t6_byte", log_at(base), 32'hC5);

    // Loopback against a behavioural transmitter, including DIV=0 and +/-3% rate skew.
    loopback(1, 16'd0, 32, "lb_div0");
    loopback(1, 16'd1, 32, "lb_div1");
    loopback(3, 16'd3, 16, "lb_div3");
    loopback(416, 16'h01A0, 1, "lb_div1a0");
    loopback(33, 16'd34, 2, "lb_plus3");
    loopback(33, 16'd32, 2, "lb_minus3");

    check("end_ovf", ovf_cnt, exp_ovf);
    check("end_ferr", ferr_cnt, exp_ferr);
    check("end_model_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
